// File: rtl/fetch_unit_if.sv
// Instruction-memory request bus between the fetch stage and imem.
// Memory accepts when req & ready and returns rdata in that same cycle.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, requests words from imem, buffers one
// instruction for decode and applies decode's redirects (no delay slot).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master imem,
    output logic [31:0]  instr,
    output logic [31:0]  instr_pc,
    output logic [31:0]  pc_plus4,
    output logic         instr_valid,
    input  logic         decode_stall,
    input  logic         branch,
    input  logic         bne,
    input  logic         alu_zero,
    input  logic [31:0]  branch_imm,
    input  logic         jtype,
    input  logic         jr,
    input  logic [31:0]  jr_target,
    input  logic [25:0]  j_index
);
    typedef enum logic {S_REQ, S_HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] hold_addr;
    logic        discard;
    logic        consume;
    logic        taken;
    logic        redirect;
    logic [31:0] target;

    assign pc_plus4 = instr_pc + 32'd4;
    assign consume  = instr_valid & ~decode_stall;
    assign taken    = branch & (alu_zero ^ bne);
    assign redirect = consume & (jr | jtype | taken);

    always_comb begin
        if (jr)
            target = {jr_target[31:2], 2'b00};
        else if (jtype)
            target = {pc_plus4[31:28], j_index, 2'b00};
        else
            target = pc_plus4 + {branch_imm[29:0], 2'b00};
    end

    // A full, stalled output register suppresses the request entirely.
    assign imem.imem_req  = (state == S_REQ) & ~(instr_valid & decode_stall);
    // While a squashed request is still outstanding the old address is kept.
    assign imem.imem_addr = discard ? hold_addr : pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            hold_addr   <= 32'h0;
            discard     <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (!imem.imem_req) begin
                        state <= S_HOLD;
                    end else if (discard) begin
                        if (imem.imem_ready)
                            discard <= 1'b0;
                    end else if (redirect) begin
                        pc          <= target;
                        instr_valid <= 1'b0;
                        if (!imem.imem_ready) begin
                            discard   <= 1'b1;
                            hold_addr <= pc;
                        end
                    end else if (imem.imem_ready) begin
                        instr       <= imem.imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + 32'd4;
                    end else if (consume) begin
                        instr_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (consume) begin
                        state       <= S_REQ;
                        instr_valid <= 1'b0;
                        if (redirect)
                            pc <= target;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: imem returns rdata = address, a small decode
// model redirects by instr_pc, and a queue holds the expected consumed PCs.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic [31:0] instr, instr_pc, pc_plus4;
    logic        instr_valid;
    logic        decode_stall;
    logic        branch, bne, alu_zero, jtype, jr;
    logic [31:0] branch_imm, jr_target;
    logic [25:0] j_index;
    logic        bne_sel;
    logic        j_phase;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    fetch_unit_if imem_bus ();
    assign imem_bus.imem_ready = ready;
    assign imem_bus.imem_rdata = imem_bus.imem_addr;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .imem(imem_bus),
        .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .decode_stall(decode_stall),
        .branch(branch), .bne(bne), .alu_zero(alu_zero), .branch_imm(branch_imm),
        .jtype(jtype), .jr(jr), .jr_target(jr_target), .j_index(j_index)
    );

    always #5 clk = ~clk;

    // Decode model: which instruction addresses are control transfers.
    always_comb begin
        branch = 1'b0; bne = 1'b0; alu_zero = 1'b0; branch_imm = 32'h0;
        jtype = 1'b0; jr = 1'b0; jr_target = 32'h0; j_index = 26'h0;
        case (instr_pc)
            32'h0000_0010: begin branch = 1'b1; bne = bne_sel; alu_zero = 1'b1; branch_imm = 32'hFFFF_FFFC; end
            32'h0000_0018: begin jtype = 1'b1; jr = 1'b1; jr_target = 32'h1000_0040; end
            32'h1000_0040: begin
                jtype = 1'b1;
                if (j_phase) begin jr = 1'b1; jr_target = 32'h0000_0203; end
                else j_index = 26'h10;
            end
            32'h0000_0200: begin jtype = 1'b1; jr = 1'b1; jr_target = 32'h0000_0080; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every instruction decode consumes must be the next expected PC.
    always @(negedge clk) begin
        if (!reset && instr_valid && !decode_stall) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL sb_unexpected observed=%h expected=none", instr_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("sb_pc", instr_pc, e);
                check("sb_instr", instr, e);
                check("sb_plus4", pc_plus4, e + 32'd4);
            end
        end
    end

    initial begin
        reset = 1'b1; ready = 1'b1; decode_stall = 1'b0; bne_sel = 1'b0; j_phase = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        @(negedge clk);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_req", {31'h0, imem_bus.imem_req}, 32'h1);
        check("rst_addr", imem_bus.imem_addr, 32'h0);

        for (int i = 1; i <= 2; i++) begin
            cyc(); @(negedge clk);
            check("seq_addr", imem_bus.imem_addr, 32'(i * 4));
            check("seq_valid", {31'h0, instr_valid}, 32'h1);
            check("seq_pc", instr_pc, 32'((i - 1) * 4));
        end

        cyc(); decode_stall = 1'b1; @(negedge clk);
        check("stall_req", {31'h0, imem_bus.imem_req}, 32'h0);
        check("stall_pc", instr_pc, 32'h8);
        repeat (2) begin
            cyc(); @(negedge clk);
            check("hold_req", {31'h0, imem_bus.imem_req}, 32'h0);
            check("hold_pc", instr_pc, 32'h8);
            check("hold_instr", instr, 32'h8);
        end
        cyc(); decode_stall = 1'b0;
        exp_q.push_back(32'hC); exp_q.push_back(32'h10);
        cyc(); @(negedge clk);
        check("resume_addr", imem_bus.imem_addr, 32'hC);
        check("resume_req", {31'h0, imem_bus.imem_req}, 32'h1);

        repeat (3) cyc();
        @(negedge clk);
        check("beq_addr", imem_bus.imem_addr, 32'h4);
        check("beq_valid", {31'h0, instr_valid}, 32'h0);
        bne_sel = 1'b1;
        exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        exp_q.push_back(32'h10); exp_q.push_back(32'h14); exp_q.push_back(32'h18);
        repeat (4) cyc();
        @(negedge clk);
        check("bne_pc", instr_pc, 32'h10);
        check("bne_addr", imem_bus.imem_addr, 32'h14);

        exp_q.push_back(32'h1000_0040); exp_q.push_back(32'h1000_0040);
        repeat (3) cyc();
        @(negedge clk);
        check("jr1_addr", imem_bus.imem_addr, 32'h1000_0040);
        repeat (2) cyc();
        j_phase = 1'b1;
        @(negedge clk);
        check("j_addr", imem_bus.imem_addr, 32'h1000_0040);
        check("j_valid", {31'h0, instr_valid}, 32'h0);
        exp_q.push_back(32'h200); exp_q.push_back(32'h80);
        repeat (2) cyc();
        @(negedge clk);
        check("jr2_addr", imem_bus.imem_addr, 32'h200);

        cyc(); ready = 1'b0; @(negedge clk);
        check("wait_addr0", imem_bus.imem_addr, 32'h204);
        for (int i = 0; i < 3; i++) begin
            cyc(); @(negedge clk);
            check("wait_addr", imem_bus.imem_addr, 32'h204);
            check("wait_req", {31'h0, imem_bus.imem_req}, 32'h1);
            check("wait_valid", {31'h0, instr_valid}, 32'h0);
        end
        cyc(); ready = 1'b1; @(negedge clk);
        check("drop_addr", imem_bus.imem_addr, 32'h204);
        cyc(); @(negedge clk);
        check("redir_addr", imem_bus.imem_addr, 32'h80);
        check("redir_valid", {31'h0, instr_valid}, 32'h0);

        exp_q.push_back(32'h84);
        cyc(); cyc(); ready = 1'b0; @(negedge clk);
        check("pend_addr", imem_bus.imem_addr, 32'h88);
        cyc(); reset = 1'b1; @(negedge clk);
        check("pend_req", {31'h0, imem_bus.imem_req}, 32'h1);
        cyc(); reset = 1'b0; ready = 1'b1; @(negedge clk);
        check("mrst_addr", imem_bus.imem_addr, 32'h0);
        check("mrst_valid", {31'h0, instr_valid}, 32'h0);
        check("mrst_pc", instr_pc, 32'h0);
        exp_q.push_back(32'h0);
        cyc(); @(negedge clk);
        check("mrst_fetch_valid", {31'h0, instr_valid}, 32'h1);
        cyc(); decode_stall = 1'b1; @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
